// File: rtl/uart_rx_sir_if.sv
// uart_rx_sir_if: received-byte handshake between the UART receiver and its consumer.
//   d_rx     : received byte, stable while rx_valid=1
//   rx_valid : byte available, held until consumed
//   rx_ready : consumer accepts d_rx on a cycle with rx_valid & rx_ready
// master = receiver side, slave = consumer side.
interface uart_rx_sir_if;
    logic [7:0] d_rx;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output d_rx, output rx_valid, input rx_ready);
    modport slave  (input d_rx, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_sir.sv
// uart_rx_sir: 8N1 serial receiver with a one-entry valid/ready holding register.
// The line is sampled at mid-bit after a two-flop synchronizer.
//   clk       : system clock, rising edge
//   rstn      : asynchronous active-low reset
//   rxd       : serial line (asynchronous, idle high)
//   rx_if     : byte handshake (d_rx / rx_valid / rx_ready)
//   frame_err : one-cycle pulse when the stop bit samples 0
//   overrun   : sticky, a completed byte was dropped while the holder was full
//   busy      : receiver FSM not idle
//
// state | meaning
// IDLE  | waiting for the line to go low
// START | checking the start bit at its mid-point
// DATA  | sampling 8 data bits, LSB first
// STOP  | checking the stop bit, delivering the byte
// BREAK | stop bit was low; wait for the line to return high
module uart_rx_sir #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rxd,
    uart_rx_sir_if.master rx_if,
    output logic          frame_err,
    output logic          overrun,
    output logic          busy
);
    localparam int N  = CLKS_PER_BIT;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          deliver, ferr;
    logic [1:0]    sync;
    logic          rxd_s;
    logic          consume;

    assign rxd_s   = sync[1];
    assign consume = rx_if.rx_valid & rx_if.rx_ready;

    always_comb begin
        state_n   = state;
        bit_cnt_n = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
        idx_n     = idx;
        sh_n      = sh;
        deliver   = 1'b0;
        ferr      = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_n = '0;
                if (!rxd_s) state_n = START;
            end
            START: begin
                if (bit_cnt == CNT_HALF) begin
                    if (!rxd_s) begin
                        state_n = DATA;
                        idx_n   = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    sh_n = {rxd_s, sh[7:1]};
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_cnt == CNT_LAST) begin
                    if (rxd_s) begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                bit_cnt_n = '0;
                if (rxd_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Every state change restarts the bit timer.
        if (state_n != state) bit_cnt_n = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync           <= 2'b11;
            state          <= IDLE;
            bit_cnt        <= '0;
            idx            <= 3'd0;
            sh             <= 8'h00;
            frame_err      <= 1'b0;
            busy           <= 1'b0;
            rx_if.d_rx     <= 8'h00;
            rx_if.rx_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            sync      <= {sync[0], rxd};
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            frame_err <= ferr;
            busy      <= (state_n != IDLE);
            // A consume in the same cycle frees the holder for the new byte.
            if (deliver && (!rx_if.rx_valid || consume)) begin
                rx_if.d_rx     <= sh;
                rx_if.rx_valid <= 1'b1;
                if (consume) overrun <= 1'b0;
            end else if (deliver) begin
                overrun <= 1'b1;
            end else if (consume) begin
                rx_if.rx_valid <= 1'b0;
                overrun        <= 1'b0;
            end
        end
    end
endmodule
